// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_ctrl
//  Purpose  : Steps a 4:1 bit-mux select through 0..3, samples the mux output
//             at the end of each dwell and assembles the samples into a word.
//  Revision : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic       y,
  output logic [1:0] s,
  output logic [3:0] word,
  output logic       word_valid,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_last = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    s_q,     s_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [3:0]    word_q,  word_d;
  logic          valid_q, valid_d;
  logic          busy_q,  busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      s_q      <= 2'b00;
      shadow_q <= 3'b000;
      word_q   <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        s_d    = 2'b00;
        cnt_d  = '0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
        end
      end

      ST_SCAN: begin
        if (stop) begin
          state_d = ST_IDLE;
          s_d     = 2'b00;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == c_last) begin
          cnt_d = '0;
          // The last sample goes straight into the word; only three need shadowing.
          case (s_q)
            2'd0: begin shadow_d[0] = y; s_d = 2'd1; end
            2'd1: begin shadow_d[1] = y; s_d = 2'd2; end
            2'd2: begin shadow_d[2] = y; s_d = 2'd3; end
            default: begin
              word_d  = {y, shadow_q};
              valid_d = 1'b1;
              s_d     = 2'b00;
              if (!continuous) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s          = s_q;
  assign word       = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_ctrl
//  Purpose  : Directed bench for mux_scan_ctrl at DWELL = 4, 2 and 1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // DWELL = 4 instance
  logic       st4 = 0, sp4 = 0, ct4 = 0;
  logic [3:0] i4 = 4'b0000;
  logic [1:0] s4;
  logic [3:0] w4;
  logic       v4, b4;
  wire        y4 = i4[s4];

  // DWELL = 2 instance
  logic       st2 = 0, sp2 = 0, ct2 = 0;
  logic [3:0] i2 = 4'b0000;
  logic [1:0] s2;
  logic [3:0] w2;
  logic       v2, b2;
  wire        y2 = i2[s2];

  // DWELL = 1 instance
  logic       st1 = 0, sp1 = 0, ct1 = 0;
  logic [3:0] i1 = 4'b0000;
  logic [1:0] s1;
  logic [3:0] w1;
  logic       v1, b1;
  wire        y1 = i1[s1];

  mux_scan_ctrl #(.DWELL(4), .CW(8)) u4 (
    .clk(clk), .rst(rst), .start(st4), .stop(sp4), .continuous(ct4), .y(y4),
    .s(s4), .word(w4), .word_valid(v4), .busy(b4));

  mux_scan_ctrl #(.DWELL(2), .CW(8)) u2 (
    .clk(clk), .rst(rst), .start(st2), .stop(sp2), .continuous(ct2), .y(y2),
    .s(s2), .word(w2), .word_valid(v2), .busy(b2));

  mux_scan_ctrl #(.DWELL(1), .CW(8)) u1 (
    .clk(clk), .rst(rst), .start(st1), .stop(sp1), .continuous(ct1), .y(y1),
    .s(s1), .word(w1), .word_valid(v1), .busy(b1));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int vcount;

    // ---------------- reset state ----------------
    tick(2);
    chk("rst_s4", {2'b0, s4}, 4'd0);
    chk("rst_w4", w4, 4'b0000);
    chk("rst_v4", {3'b0, v4}, 4'd0);
    chk("rst_b4", {3'b0, b4}, 4'd0);
    chk("rst_b2", {3'b0, b2}, 4'd0);
    chk("rst_w1", w1, 4'b0000);
    rst = 1'b0;
    tick(2);

    // ---------------- stop / start in IDLE ----------------
    sp4 = 1; tick();
    chk("idle_stop_busy", {3'b0, b4}, 4'd0);
    st4 = 1; tick();
    chk("idle_startstop_busy", {3'b0, b4}, 4'd0);
    chk("idle_startstop_s", {2'b0, s4}, 4'd0);
    st4 = 0; sp4 = 0; tick();

    // ---------------- abort at edge 10 ----------------
    i4 = 4'b1111;
    st4 = 1; tick(); st4 = 0;              // edge 0
    chk("abort_busy_e0", {3'b0, b4}, 4'd1);
    tick(9);                               // edge 9
    chk("abort_s_e9", {2'b0, s4}, 4'd2);
    sp4 = 1; tick(); sp4 = 0;              // edge 10
    chk("abort_busy", {3'b0, b4}, 4'd0);
    chk("abort_s", {2'b0, s4}, 4'd0);
    chk("abort_word", w4, 4'b0000);
    vcount = 0;
    for (int n = 11; n <= 20; n++) begin
      tick();
      if (v4) vcount++;
    end
    chk("abort_no_valid", vcount[3:0], 4'd0);
    chk("abort_word_after", w4, 4'b0000);

    // ---------------- single scan, DWELL=4, i=1010 ----------------
    i4 = 4'b1010;
    st4 = 1; tick(); st4 = 0;              // edge 0
    chk("ss_s_e0", {2'b0, s4}, 4'd0);
    chk("ss_busy_e0", {3'b0, b4}, 4'd1);
    for (int n = 1; n <= 15; n++) begin
      tick();
      chk($sformatf("ss_s_e%0d", n), {2'b0, s4}, 4'(n / 4));
      chk($sformatf("ss_v_e%0d", n), {3'b0, v4}, 4'd0);
    end
    tick();                                // edge 16
    chk("ss_word", w4, 4'b1010);
    chk("ss_valid", {3'b0, v4}, 4'd1);
    chk("ss_busy_e16", {3'b0, b4}, 4'd0);
    chk("ss_s_e16", {2'b0, s4}, 4'd0);
    tick();
    chk("ss_valid_e17", {3'b0, v4}, 4'd0);
    chk("ss_word_hold", w4, 4'b1010);

    // ---------------- stop on final sample edge ----------------
    i4 = 4'b0101;
    st4 = 1; tick(); st4 = 0;              // edge 0
    tick(15);                              // edge 15
    sp4 = 1; tick(); sp4 = 0;              // edge 16
    chk("col_stop_valid", {3'b0, v4}, 4'd0);
    chk("col_stop_word", w4, 4'b1010);
    chk("col_stop_busy", {3'b0, b4}, 4'd0);
    tick();
    chk("col_stop_valid_e17", {3'b0, v4}, 4'd0);

    // ---------------- start held during scan ----------------
    st4 = 1; tick();                       // edge 0
    vcount = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 16) st4 = 0;
      tick();
      if (v4) vcount++;
      if (n == 4)  chk("hold_s_e4", {2'b0, s4}, 4'd1);
      if (n == 8)  chk("hold_s_e8", {2'b0, s4}, 4'd2);
      if (n == 15) chk("hold_busy_e15", {3'b0, b4}, 4'd1);
    end
    chk("hold_valid_e16", {3'b0, v4}, 4'd1);
    chk("hold_word", w4, 4'b0101);
    chk("hold_one_valid", vcount[3:0], 4'd1);
    tick();
    chk("hold_idle_after", {3'b0, b4}, 4'd0);

    // ---------------- continuous, DWELL=2 ----------------
    i2 = 4'b0110; ct2 = 1;
    st2 = 1; tick(); st2 = 0;              // edge 0
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk($sformatf("ct_busy_e%0d", n), {3'b0, b2}, 4'd1);
      chk($sformatf("ct_s_e%0d", n), {2'b0, s2}, 4'((n % 8) / 2));
      chk($sformatf("ct_v_e%0d", n), {3'b0, v2}, (n % 8 == 0) ? 4'd1 : 4'd0);
      if (n == 8) begin
        chk("ct_word1", w2, 4'b0110);
        i2 = 4'b1001;
      end
    end
    chk("ct_word2", w2, 4'b1001);
    ct2 = 0;
    tick(8);                               // edge 24
    chk("ct_end_valid", {3'b0, v2}, 4'd1);
    chk("ct_end_busy", {3'b0, b2}, 4'd0);
    chk("ct_end_word", w2, 4'b1001);

    // ---------------- DWELL=1, i=0011 ----------------
    i1 = 4'b0011;
    st1 = 1; tick(); st1 = 0;              // edge 0
    chk("d1_s_e0", {2'b0, s1}, 4'd0);
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk($sformatf("d1_s_e%0d", n), {2'b0, s1}, 4'(n));
    end
    tick();                                // edge 4
    chk("d1_word", w1, 4'b0011);
    chk("d1_valid", {3'b0, v1}, 4'd1);
    chk("d1_busy", {3'b0, b1}, 4'd0);

    // ---------------- async reset mid-scan ----------------
    i4 = 4'b1111;
    st4 = 1; tick(); st4 = 0;              // edge 0
    tick(9);                               // edge 9
    chk("ar_s_pre", {2'b0, s4}, 4'd2);
    chk("ar_word_pre", w4, 4'b0101);
    rst = 1'b1;
    #2;
    chk("ar_s", {2'b0, s4}, 4'd0);
    chk("ar_word", w4, 4'b0000);
    chk("ar_valid", {3'b0, v4}, 4'd0);
    chk("ar_busy", {3'b0, b4}, 4'd0);
    #1 rst = 1'b0;
    tick();
    i4 = 4'b1100;
    st4 = 1; tick(); st4 = 0;              // edge 0
    chk("ar_rescan_busy", {3'b0, b4}, 4'd1);
    tick(15);
    chk("ar_rescan_v15", {3'b0, v4}, 4'd0);
    tick();                                // edge 16
    chk("ar_rescan_word", w4, 4'b1100);
    chk("ar_rescan_valid", {3'b0, v4}, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
